// File: rtl/estacionamiento_pkg.sv
// estacionamiento_pkg: shared state encoding, default timings and direction codes for the parking lane
package estacionamiento_pkg;
  localparam int T_ABRIR_DEF  = 4;
  localparam int T_CERRAR_DEF = 4;
  localparam int T_ESPERA_DEF = 16;
  localparam logic SENTIDO_ENTRA = 1'b0;
  localparam logic SENTIDO_SALE  = 1'b1;
  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    ABRIENDO    = 3'd1,
    ESPERA_PASO = 3'd2,
    PASANDO     = 3'd3,
    CERRANDO    = 3'd4
  } estado_t;
endpackage

// File: rtl/temporizador_barrera.sv
// temporizador_barrera: loadable down-counter that saturates at zero
module temporizador_barrera #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [TW-1:0] valor,
  input  logic          habilita,
  output logic          cero
);
  logic [TW-1:0] cuenta;
  always_ff @(posedge clk)
    if (reset) cuenta <= '0;
    else if (carga) cuenta <= valor;
    else if (habilita && !cero) cuenta <= cuenta - TW'(1);
  assign cero = (cuenta == '0);
endmodule

// File: rtl/control_barrera_estacionamiento.sv
// control_barrera_estacionamiento: arbitrates the shared entry/exit lane and sequences the barrier motor
module control_barrera_estacionamiento
  import estacionamiento_pkg::*;
#(
  parameter int T_ABRIR  = T_ABRIR_DEF,
  parameter int T_CERRAR = T_CERRAR_DEF,
  parameter int T_ESPERA = T_ESPERA_DEF,
  parameter int TW       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_entrada,
  input  logic sensor_salida,
  input  logic sensor_paso,
  input  logic lleno,
  input  logic vacio,
  output logic motor_abrir,
  output logic motor_cerrar,
  output logic barrera_arriba,
  output logic sentido,
  output logic auto_entra,
  output logic auto_sale,
  output logic timeout
);
  estado_t estado, estado_n;
  logic prioridad, prioridad_n, sentido_n, pulsado, pulsado_n;
  logic req_e, req_s, pulso, fin_espera;
  logic carga, habilita, cero;
  logic [TW-1:0] valor;
  assign req_e = sensor_entrada & ~lleno;
  assign req_s = sensor_salida & ~vacio;
  assign habilita = (estado != REPOSO);
  temporizador_barrera #(.TW(TW)) u_temp (
    .clk(clk), .reset(reset), .carga(carga), .valor(valor), .habilita(habilita), .cero(cero)
  );
  always_comb begin
    estado_n = estado;
    prioridad_n = prioridad;
    sentido_n = sentido;
    pulsado_n = pulsado;
    carga = 1'b0;
    valor = '0;
    pulso = 1'b0;
    fin_espera = 1'b0;
    case (estado)
      REPOSO: if (req_e || req_s) begin
        sentido_n = (req_e && req_s) ? prioridad : (req_s ? SENTIDO_SALE : SENTIDO_ENTRA);
        prioridad_n = ~sentido_n;
        pulsado_n = 1'b0;
        carga = 1'b1;
        valor = TW'(T_ABRIR - 1);
        estado_n = ABRIENDO;
      end
      ABRIENDO: if (cero) begin
        carga = 1'b1;
        valor = TW'(T_ESPERA - 1);
        estado_n = ESPERA_PASO;
      end
      ESPERA_PASO: if (sensor_paso) estado_n = PASANDO;
        else if (cero) begin
          fin_espera = 1'b1;
          carga = 1'b1;
          valor = TW'(T_CERRAR - 1);
          estado_n = CERRANDO;
        end
      // a car re-passing after a safety reopen must not be counted twice
      PASANDO: if (!sensor_paso) begin
        pulso = ~pulsado;
        pulsado_n = 1'b1;
        carga = 1'b1;
        valor = TW'(T_CERRAR - 1);
        estado_n = CERRANDO;
      end
      CERRANDO: if (sensor_paso) begin
          carga = 1'b1;
          valor = TW'(T_ABRIR - 1);
          estado_n = ABRIENDO;
        end else if (cero) estado_n = REPOSO;
      default: estado_n = REPOSO;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      estado <= REPOSO;
      prioridad <= SENTIDO_ENTRA;
      sentido <= SENTIDO_ENTRA;
      pulsado <= 1'b0;
      motor_abrir <= 1'b0;
      motor_cerrar <= 1'b0;
      barrera_arriba <= 1'b0;
      auto_entra <= 1'b0;
      auto_sale <= 1'b0;
      timeout <= 1'b0;
    end else begin
      estado <= estado_n;
      prioridad <= prioridad_n;
      sentido <= sentido_n;
      pulsado <= pulsado_n;
      motor_abrir <= (estado_n == ABRIENDO);
      motor_cerrar <= (estado_n == CERRANDO);
      barrera_arriba <= (estado_n == ESPERA_PASO) || (estado_n == PASANDO);
      auto_entra <= pulso && (sentido_n == SENTIDO_ENTRA);
      auto_sale <= pulso && (sentido_n == SENTIDO_SALE);
      timeout <= fin_espera;
    end
endmodule

// File: tb/tb_control_barrera_estacionamiento.sv
// tb_control_barrera_estacionamiento: scenario tasks plus randomized grants checked against a lane/lot model
module tb_control_barrera_estacionamiento;
  localparam int TA = 4, TC = 4, TE = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic sensor_entrada = 1'b0, sensor_salida = 1'b0, sensor_paso = 1'b0;
  logic lleno, vacio;
  logic motor_abrir, motor_cerrar, barrera_arriba, sentido, auto_entra, auto_sale, timeout;
  int tests = 0, fails = 0, count = 0, cyc = 0;
  int ne, ns, nto, ncerr, t_to, t_grant;
  logic mprio;
  assign lleno = (count == 7);
  assign vacio = (count == 0);
  always #5 clk = ~clk;
  control_barrera_estacionamiento dut (
    .clk(clk), .reset(reset), .sensor_entrada(sensor_entrada), .sensor_salida(sensor_salida),
    .sensor_paso(sensor_paso), .lleno(lleno), .vacio(vacio), .motor_abrir(motor_abrir),
    .motor_cerrar(motor_cerrar), .barrera_arriba(barrera_arriba), .sentido(sentido),
    .auto_entra(auto_entra), .auto_sale(auto_sale), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_entra) begin count++; ne++; end
    if (auto_sale) begin count--; ns++; end
    if (timeout) begin nto++; t_to = cyc; end
    if (motor_cerrar) ncerr++;
    tests++;
    if ((motor_abrir && motor_cerrar) || (auto_entra && auto_sale)) begin
      fails++;
      $display("FAIL exclusive: abrir=%b cerrar=%b entra=%b sale=%b, required never two high", motor_abrir, motor_cerrar, auto_entra, auto_sale);
    end
  endtask

  task automatic do_reset();
    sensor_entrada = 0; sensor_salida = 0; sensor_paso = 0;
    reset = 1;
    tick();
    reset = 0;
    mprio = 0;
  endtask

  task automatic ciclo(input logic ent, input logic sal, input int d, input int len,
                       output logic granted, output logic sent, output int lat, output int up, output logic fin);
    logic seen;
    ne = 0; ns = 0; nto = 0; ncerr = 0; t_to = -1;
    granted = 0; sent = 0; lat = 0; up = 0; fin = 0; seen = 0;
    sensor_entrada = ent; sensor_salida = sal;
    for (int i = 0; i < 8 && !granted; i++) begin tick(); lat++; granted = motor_abrir; end
    sensor_entrada = 0; sensor_salida = 0;
    if (granted) begin
      sent = sentido; t_grant = cyc;
      for (int i = 0; i < 10 && !barrera_arriba; i++) begin tick(); up++; end
      repeat (d) tick();
      if (len > 0) begin sensor_paso = 1; repeat (len) tick(); sensor_paso = 0; end
      for (int i = 0; i < 60 && !fin; i++) begin
        tick();
        seen = seen | motor_cerrar;
        fin = seen && !motor_abrir && !motor_cerrar && !barrera_arriba;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({motor_abrir, motor_cerrar, barrera_arriba, sentido, auto_entra, auto_sale, timeout} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0000000", {motor_abrir, motor_cerrar, barrera_arriba, sentido, auto_entra, auto_sale, timeout});
    end
  endtask

  task automatic test_entry();
    logic g, s, f; int lat, up;
    do_reset(); count = 0;
    ciclo(1, 0, 3, 3, g, s, lat, up, f);
    tests += 9;
    if (g !== 1'b1) begin fails++; $display("FAIL entry_grant: got %b required 1", g); end
    if (s !== 1'b0) begin fails++; $display("FAIL entry_sentido: got %b required 0", s); end
    if (lat != 1) begin fails++; $display("FAIL entry_latency: got %0d required 1", lat); end
    if (up != TA) begin fails++; $display("FAIL entry_open_time: got %0d required %0d", up, TA); end
    if (ne != 1) begin fails++; $display("FAIL entry_pulses: got %0d required 1", ne); end
    if (ns != 0 || nto != 0) begin fails++; $display("FAIL entry_other_pulses: sale=%0d timeout=%0d required 0", ns, nto); end
    if (ncerr != TC) begin fails++; $display("FAIL entry_close_time: got %0d required %0d", ncerr, TC); end
    if (count != 1) begin fails++; $display("FAIL entry_count: got %0d required 1", count); end
    if (f !== 1'b1) begin fails++; $display("FAIL entry_idle: got %b required 1", f); end
  endtask

  task automatic test_alternancia();
    logic g, s, f, es; int lat, up, ec;
    do_reset(); count = 3; ec = 3;
    for (int k = 0; k < 4; k++) begin
      es = mprio;
      ec = es ? ec - 1 : ec + 1;
      ciclo(1, 1, 1, 2, g, s, lat, up, f);
      mprio = ~es;
      tests += 2;
      if (g !== 1'b1 || s !== es) begin fails++; $display("FAIL alternate_side[%0d]: grant=%b sentido=%b required 1/%b", k, g, s, es); end
      if (count != ec) begin fails++; $display("FAIL alternate_count[%0d]: got %0d required %0d", k, count, ec); end
    end
  endtask

  task automatic test_lleno();
    logic g, s, f; int lat, up;
    do_reset(); count = 7;
    ciclo(1, 0, 0, 2, g, s, lat, up, f);
    tests++;
    if (g !== 1'b0) begin fails++; $display("FAIL full_refuse: grant=%b required 0", g); end
    ciclo(1, 1, 2, 2, g, s, lat, up, f);
    tests += 3;
    if (g !== 1'b1 || s !== 1'b1) begin fails++; $display("FAIL full_exit_grant: grant=%b sentido=%b required 1/1", g, s); end
    if (ns != 1 || ne != 0) begin fails++; $display("FAIL full_exit_pulse: sale=%0d entra=%0d required 1/0", ns, ne); end
    if (count != 6) begin fails++; $display("FAIL full_exit_count: got %0d required 6", count); end
  endtask

  task automatic test_timeout();
    logic g, s, f; int lat, up;
    do_reset(); count = 2;
    ciclo(1, 0, 0, 0, g, s, lat, up, f);
    tests += 5;
    if (g !== 1'b1) begin fails++; $display("FAIL timeout_grant: got %b required 1", g); end
    if (nto != 1) begin fails++; $display("FAIL timeout_pulses: got %0d required 1", nto); end
    if (t_to - t_grant != TA + TE) begin fails++; $display("FAIL timeout_delay: got %0d required %0d", t_to - t_grant, TA + TE); end
    if (ne + ns != 0 || count != 2) begin fails++; $display("FAIL timeout_count: pulses=%0d count=%0d required 0/2", ne + ns, count); end
    if (f !== 1'b1) begin fails++; $display("FAIL timeout_idle: got %b required 1", f); end
  endtask

  task automatic test_reapertura();
    logic f;
    do_reset(); count = 0; ne = 0; ns = 0; f = 0;
    sensor_entrada = 1; tick(); sensor_entrada = 0;
    for (int i = 0; i < 10 && !barrera_arriba; i++) tick();
    sensor_paso = 1; tick(); tick(); sensor_paso = 0;
    tick();
    sensor_paso = 1; tick();
    tests++;
    if (motor_abrir !== 1'b1 || motor_cerrar !== 1'b0) begin fails++; $display("FAIL reopen_motor: abrir=%b cerrar=%b required 1/0", motor_abrir, motor_cerrar); end
    repeat (6) tick();
    sensor_paso = 0;
    for (int i = 0; i < 30 && !f; i++) begin tick(); f = !motor_abrir && !motor_cerrar && !barrera_arriba; end
    tests += 3;
    if (ne != 1 || ns != 0) begin fails++; $display("FAIL reopen_pulses: entra=%0d sale=%0d required 1/0", ne, ns); end
    if (count != 1) begin fails++; $display("FAIL reopen_count: got %0d required 1", count); end
    if (f !== 1'b1) begin fails++; $display("FAIL reopen_idle: got %b required 1", f); end
  endtask

  task automatic test_reset_pasando();
    do_reset(); count = 5; ne = 0; ns = 0;
    sensor_salida = 1; tick(); sensor_salida = 0;
    for (int i = 0; i < 10 && !barrera_arriba; i++) tick();
    sensor_paso = 1; tick(); tick();
    tests++;
    if (barrera_arriba !== 1'b1) begin fails++; $display("FAIL midreset_up: got %b required 1", barrera_arriba); end
    reset = 1; tick(); reset = 0; mprio = 0;
    tests++;
    if ({motor_abrir, motor_cerrar, barrera_arriba, sentido, auto_entra, auto_sale, timeout} !== 7'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b required 0000000", {motor_abrir, motor_cerrar, barrera_arriba, sentido, auto_entra, auto_sale, timeout});
    end
    sensor_paso = 0;
    repeat (8) tick();
    tests += 2;
    if (ne + ns != 0 || count != 5) begin fails++; $display("FAIL midreset_count: pulses=%0d count=%0d required 0/5", ne + ns, count); end
    if (motor_abrir !== 1'b0) begin fails++; $display("FAIL midreset_idle: abrir=%b required 0", motor_abrir); end
  endtask

  task automatic test_aleatorio();
    logic g, s, f, ent, sal, re, rs, eg, es; int lat, up, d, len, ec;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      ent = 1'($urandom_range(0, 1)); sal = 1'($urandom_range(0, 1));
      count = $urandom_range(0, 7);
      d = $urandom_range(0, 5);
      len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4);
      re = ent && count < 7; rs = sal && count > 0;
      eg = re || rs;
      es = (re && rs) ? mprio : rs;
      ec = (eg && len > 0) ? (es ? count - 1 : count + 1) : count;
      ciclo(ent, sal, d, len, g, s, lat, up, f);
      tests++;
      if (g !== eg) begin fails++; $display("FAIL rand_grant[%0d]: got %b required %b", k, g, eg); end
      if (eg) begin
        mprio = ~es;
        tests += 5;
        if (s !== es) begin fails++; $display("FAIL rand_sentido[%0d]: got %b required %b", k, s, es); end
        if (lat != 1 || up != TA) begin fails++; $display("FAIL rand_timing[%0d]: lat=%0d up=%0d required 1/%0d", k, lat, up, TA); end
        if (ne != int'(len > 0 && !es) || ns != int'(len > 0 && es) || nto != int'(len == 0)) begin
          fails++; $display("FAIL rand_pulses[%0d]: entra=%0d sale=%0d timeout=%0d len=%0d side=%b", k, ne, ns, nto, len, es);
        end
        if (count != ec) begin fails++; $display("FAIL rand_count[%0d]: got %0d required %0d", k, count, ec); end
        if (f !== 1'b1) begin fails++; $display("FAIL rand_idle[%0d]: got %b required 1", k, f); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_alternancia();
    test_lleno();
    test_timeout();
    test_reapertura();
    test_reset_pasando();
    test_aleatorio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
